interboard_msg_sender: RTL

Serializes one game-control message from the draw/place controller (the `*_ctrl_*` bundle) onto the 4-bit inter-board link using a four-phase req/ack handshake. It sits directly downstream of `draw_one_place_send_msg`. It produces the `inter_ready` pulse that lets that block advance to its next message. Each message is 22 payload bits, 2 pad bits and a 4-bit XOR checksum, sent as 7 nibbles, MSB first.

---
 rtl/interboard_msg_sender.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/interboard_msg_sender.sv
// Serializes one 24-bit game-control message plus XOR checksum onto the 4-bit
// inter-board link as seven nibbles, using a four-phase req/ack handshake.
module interboard_msg_sender #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       ctrl_en,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [2:0] ctrl_sel_len,
    input  logic       ctrl_move_dir,
    input  logic       send_ack,
    output logic       send_req,
    output logic [3:0] send_data,
    output logic       busy,
    output logic       inter_ready,
    output logic       inter_fail,
    output logic       overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ_HI = 2'd1;
    localparam logic [1:0] S_REQ_LO = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_NIB  = 3'd6;

    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [19:0] r_cnt;
    logic [23:0] r_msg;
    logic [3:0]  r_chk;
    logic        r_ack_meta;
    logic        r_ack_s;
    logic        r_send_req;
    logic [3:0]  r_send_data;
    logic        r_busy;
    logic        r_inter_ready;
    logic        r_inter_fail;
    logic        r_overrun;

    logic [1:0]  w_next_state;
    logic        w_capture;
    logic        w_idx_inc;
    logic        w_fail;
    logic        w_timeout;
    logic [23:0] w_new_msg;

    function automatic logic [3:0] f_checksum(input logic [23:0] msg);
        return msg[23:20] ^ msg[19:16] ^ msg[15:12] ^ msg[11:8] ^ msg[7:4] ^ msg[3:0];
    endfunction

    function automatic logic [3:0] f_nibble(input logic [23:0] msg, input logic [3:0] chk,
                                            input logic [2:0] idx);
        case (idx)
            3'd0:    return msg[23:20];
            3'd1:    return msg[19:16];
            3'd2:    return msg[15:12];
            3'd3:    return msg[11:8];
            3'd4:    return msg[7:4];
            3'd5:    return msg[3:0];
            default: return chk;
        endcase
    endfunction

    assign w_new_msg = {ctrl_msg_type, ctrl_card, ctrl_block_x, ctrl_block_y,
                        ctrl_sel_len, ctrl_move_dir, 2'b00};
    assign w_timeout = (r_cnt == TO_LAST);

    // The remote ack is asynchronous; the soft reset deliberately leaves these flops alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= send_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_idx_inc    = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_en) begin
                    w_next_state = S_REQ_HI;
                    w_capture    = 1'b1;
                end
            end
            S_REQ_HI: begin
                if (r_ack_s) begin
                    w_next_state = S_REQ_LO;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_fail       = 1'b1;
                end
            end
            S_REQ_LO: begin
                if (!r_ack_s) begin
                    if (r_idx == LAST_NIB) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_REQ_HI;
                        w_idx_inc    = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_fail       = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decision, so none is combinational.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 3'd0;
            r_cnt         <= 20'd0;
            r_send_req    <= 1'b0;
            r_send_data   <= 4'd0;
            r_busy        <= 1'b0;
            r_inter_ready <= 1'b0;
            r_inter_fail  <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (interboard_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 3'd0;
            r_cnt         <= 20'd0;
            r_send_req    <= 1'b0;
            r_send_data   <= 4'd0;
            r_busy        <= 1'b0;
            r_inter_ready <= 1'b0;
            r_inter_fail  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_send_req    <= (w_next_state == S_REQ_HI);
            r_busy        <= (w_next_state != S_IDLE);
            r_inter_ready <= (w_next_state == S_DONE);
            r_inter_fail  <= w_fail;
            if (ctrl_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                r_idx       <= 3'd0;
                r_send_data <= w_new_msg[23:20];
            end else if (w_idx_inc) begin
                r_idx       <= r_idx + 3'd1;
                r_send_data <= f_nibble(r_msg, r_chk, r_idx + 3'd1);
            end
            if (w_next_state != r_state) begin
                r_cnt <= 20'd0;
            end else if ((r_state == S_REQ_HI) || (r_state == S_REQ_LO)) begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture && !interboard_rst) begin
            r_msg <= w_new_msg;
            r_chk <= f_checksum(w_new_msg);
        end
    end

    assign send_req    = r_send_req;
    assign send_data   = r_send_data;
    assign busy        = r_busy;
    assign inter_ready = r_inter_ready;
    assign inter_fail  = r_inter_fail;
    assign overrun     = r_overrun;

endmodule
